// File: rtl/repetition_ecc_pkg.sv
// Shared definitions for the repetition ECC receive path: default geometry,
// codeword/counter width helpers and the deserializer state type.
package repetition_ecc_pkg;

   localparam int DEFAULT_DATA_WIDTH        = 8;
   localparam int DEFAULT_REPETITION_FACTOR = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic int cw_width(input int data_width, input int repetition_factor);
      return data_width * repetition_factor;
   endfunction

   // Wide enough to count 0..CW inclusive
   function automatic int cnt_width(input int cw);
      return $clog2(cw + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over inc.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/repetition_codeword_deserializer.sv
// Assembles a framed serial bit stream into repetition codewords and holds
// each one in a single-entry valid/ready register for the ECC decoder.
module repetition_codeword_deserializer
   import repetition_ecc_pkg::*;
#(
   parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
   parameter int REPETITION_FACTOR = DEFAULT_REPETITION_FACTOR
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  bit_in,
   input  logic                                  bit_valid,
   input  logic                                  sof,
   input  logic                                  clear_stats,
   output logic [DATA_WIDTH*REPETITION_FACTOR-1:0] codeword_out,
   output logic                                  cw_valid,
   input  logic                                  cw_ready,
   output logic                                  busy,
   output logic                                  abort,
   output logic                                  overflow,
   output logic [15:0]                           frame_count
);

   localparam int CW    = cw_width(DATA_WIDTH, REPETITION_FACTOR);
   localparam int CNT_W = cnt_width(CW);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CW-1:0]    shift_reg;
   logic             last_bit;
   logic             complete;
   logic             consume;
   logic             load;
   logic             drop;

   // A final bit carrying sof restarts the frame instead of completing it
   assign last_bit = (cnt == CNT_W'(CW - 1));
   assign complete = (state == SHIFT) && bit_valid && !sof && last_bit;
   assign consume  = cw_valid && cw_ready;
   assign load     = complete && (!cw_valid || cw_ready);
   assign drop     = complete && cw_valid && !cw_ready;
   assign busy     = (state == SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         shift_reg <= '0;
         abort     <= 1'b0;
      end else begin
         abort <= 1'b0;
         if (bit_valid) begin
            unique case (state)
               IDLE: begin
                  if (sof) begin
                     shift_reg[0] <= bit_in;
                     cnt          <= CNT_W'(1);
                     state        <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (sof) begin
                     abort        <= 1'b1;
                     shift_reg[0] <= bit_in;
                     cnt          <= CNT_W'(1);
                  end else begin
                     for (int i = 0; i < CW; i++) begin
                        if (cnt == CNT_W'(i)) shift_reg[i] <= bit_in;
                     end
                     if (last_bit) begin
                        cnt   <= '0;
                        state <= IDLE;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   // The completing bit is merged directly so the codeword is ready one edge after it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         codeword_out <= '0;
         cw_valid     <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         if (load) begin
            codeword_out <= {bit_in, shift_reg[CW-2:0]};
            cw_valid     <= 1'b1;
         end else if (consume) begin
            cw_valid <= 1'b0;
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (clear_stats) begin
            overflow <= 1'b0;
         end
      end
   end

   sat_counter #(
      .WIDTH(16)
   ) u_frame_count (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (load),
      .clear(clear_stats),
      .count(frame_count)
   );

endmodule

// File: tb/tb_repetition_codeword_deserializer.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a frame-level reference model of the deserializer.
module tb_repetition_codeword_deserializer;

   localparam int CW = 24;

   logic          clk;
   logic          rst_n;
   logic          bit_in;
   logic          bit_valid;
   logic          sof;
   logic          clear_stats;
   logic [CW-1:0] codeword_out;
   logic          cw_valid;
   logic          cw_ready;
   logic          busy;
   logic          abort;
   logic          overflow;
   logic [15:0]   frame_count;

   int checkCount = 0;
   int failCount  = 0;

   // Reference model state: frame content as a list of received bits
   bit            mInFrame;
   bit            mBits[$];
   logic [CW-1:0] mHold;
   bit            mValid;
   int            mFrames;
   bit            mOverflow;
   bit            mAbort;

   repetition_codeword_deserializer #(
      .DATA_WIDTH(8),
      .REPETITION_FACTOR(3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .sof         (sof),
      .clear_stats (clear_stats),
      .codeword_out(codeword_out),
      .cw_valid    (cw_valid),
      .cw_ready    (cw_ready),
      .busy        (busy),
      .abort       (abort),
      .overflow    (overflow),
      .frame_count (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [CW-1:0] encode(input logic [7:0] data);
      logic [CW-1:0] cw;
      cw = '0;
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < 3; k++)
            cw[i*3+k] = data[i];
      return cw;
   endfunction

   function automatic void resetModel();
      mInFrame  = 0;
      mBits     = {};
      mHold     = '0;
      mValid    = 0;
      mFrames   = 0;
      mOverflow = 0;
      mAbort    = 0;
   endfunction

   function automatic void modelStep(input bit bv, input bit b, input bit s, input bit rdy, input bit clr);
      bit            done;
      bit            consumed;
      bit            dropped;
      logic [CW-1:0] frame;
      done     = 0;
      dropped  = 0;
      mAbort   = 0;
      consumed = mValid && rdy;
      if (bv) begin
         if (s) begin
            mAbort   = mInFrame;
            mBits    = {b};
            mInFrame = 1;
         end else if (mInFrame) begin
            mBits.push_back(b);
            if (mBits.size() == CW) begin
               done     = 1;
               mInFrame = 0;
            end
         end
      end
      if (consumed) mValid = 0;
      if (done) begin
         if (!mValid) begin
            frame = '0;
            foreach (mBits[n]) frame[n] = mBits[n];
            mHold   = frame;
            mValid  = 1;
            mFrames = (mFrames == 65535) ? 65535 : mFrames + 1;
         end else begin
            dropped = 1;
         end
         mBits = {};
      end
      if (clr) mFrames = 0;
      if (dropped) mOverflow = 1;
      else if (clr) mOverflow = 0;
   endfunction

   task automatic compareModel();
      checkOutput("codeword_out", 32'(codeword_out), 32'(mHold));
      checkOutput("cw_valid", 32'(cw_valid), 32'(mValid));
      checkOutput("busy", 32'(busy), 32'(mInFrame));
      checkOutput("abort", 32'(abort), 32'(mAbort));
      checkOutput("overflow", 32'(overflow), 32'(mOverflow));
      checkOutput("frame_count", 32'(frame_count), 32'(mFrames));
   endtask

   // One clock: drive at negedge, sample 1 ns after the rising edge
   task automatic applyStimulus(input bit bv, input bit b, input bit s, input bit rdy, input bit clr);
      @(negedge clk);
      bit_valid   = bv;
      bit_in      = b;
      sof         = s;
      cw_ready    = rdy;
      clear_stats = clr;
      @(posedge clk);
      #1;
      modelStep(bv, b, s, rdy, clr);
      compareModel();
   endtask

   task automatic sendFrame(input logic [CW-1:0] cw, input bit gap, input bit rdyAll,
                            input bit rdyLast, input bit clrLast);
      for (int n = 0; n < CW; n++) begin
         if (gap && n > 0) applyStimulus(0, 1'($urandom), 0, rdyAll, 0);
         applyStimulus(1, cw[n], n == 0, (n == CW-1) ? rdyLast : rdyAll,
                       (n == CW-1) ? clrLast : 1'b0);
      end
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      bit_valid   = 0;
      sof         = 0;
      cw_ready    = 0;
      clear_stats = 0;
      resetModel();
      compareModel();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [CW-1:0] cwA5;
      logic [CW-1:0] cwNew;
      rst_n = 1'b0; bit_in = 0; bit_valid = 0; sof = 0; cw_ready = 0; clear_stats = 0;
      resetModel();
      repeat (3) @(posedge clk);
      #1;
      compareModel();
      @(negedge clk);
      rst_n = 1'b1;

      cwA5 = encode(8'hA5);
      checkOutput("encode A5", 32'(cwA5), 32'h00E381C7);

      // Reset mid-frame, then stray bits without sof are ignored
      for (int n = 0; n < 10; n++) applyStimulus(1, 1'($urandom), n == 0, 0, 0);
      checkOutput("T1 busy mid", 32'(busy), 32'd1);
      applyReset();
      for (int n = 0; n < 5; n++) applyStimulus(1, 1'($urandom), 0, 0, 0);
      checkOutput("T1 busy idle", 32'(busy), 32'd0);

      // Single frame held until consumed
      sendFrame(cwA5, 0, 0, 0, 0);
      checkOutput("T2 cw", 32'(codeword_out), 32'h00E381C7);
      checkOutput("T2 fc", 32'(frame_count), 32'd1);
      repeat (3) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("T2 valid held", 32'(cw_valid), 32'd1);

      // Dropped frame, then a completion coinciding with consumption
      sendFrame(cwA5, 0, 0, 0, 0);
      checkOutput("T3 overflow", 32'(overflow), 32'd1);
      checkOutput("T3 fc drop", 32'(frame_count), 32'd1);
      checkOutput("T3 cw drop", 32'(codeword_out), 32'h00E381C7);
      sendFrame(cwA5, 0, 0, 1, 0);
      checkOutput("T3 fc load", 32'(frame_count), 32'd2);
      checkOutput("T3 valid", 32'(cw_valid), 32'd1);

      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("T6 clr overflow", 32'(overflow), 32'd0);
      checkOutput("T6 clr fc", 32'(frame_count), 32'd0);

      // Abort by a new sof after 10 bits
      for (int n = 0; n < 10; n++) applyStimulus(1, 1'($urandom), n == 0, n == 0, 0);
      cwNew = encode(8'h69);
      applyStimulus(1, cwNew[0], 1, 0, 0);
      checkOutput("T4 abort", 32'(abort), 32'd1);
      checkOutput("T4 busy", 32'(busy), 32'd1);
      for (int n = 1; n < CW; n++) begin
         applyStimulus(1, cwNew[n], 0, 0, 0);
         if (n == 1) checkOutput("T4 abort pulse", 32'(abort), 32'd0);
         if (n == CW-2) checkOutput("T4 no early cw", 32'(cw_valid), 32'd0);
      end
      checkOutput("T4 cw", 32'(codeword_out), 32'(cwNew));
      checkOutput("T4 valid", 32'(cw_valid), 32'd1);

      // Every-other-cycle bits
      applyStimulus(0, 0, 0, 1, 0);
      sendFrame(encode(8'h3C), 1, 0, 0, 0);
      checkOutput("T5 cw", 32'(codeword_out), 32'h0003FFC0);
      checkOutput("T5 valid", 32'(cw_valid), 32'd1);

      // Clear coinciding with a drop: set wins for overflow, clear wins for count
      sendFrame(cwA5, 0, 0, 0, 1);
      checkOutput("T6 drop overflow", 32'(overflow), 32'd1);
      checkOutput("T6 drop fc", 32'(frame_count), 32'd0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         applyStimulus(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 39) == 0),
                       1'($urandom), ($urandom_range(0, 59) == 0));
         if (c == 1500) applyReset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
